// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and line type for the keypad sense-line debouncer
package keypad_pkg;
  localparam int KP_CHANNELS = 4;
  localparam int KP_STABLE_TICKS_DEF = 4;
  localparam int KP_TICK_DIV_DEF = 100000;
  typedef logic [KP_CHANNELS-1:0] kp_lines_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one sense line -> 2-FF synchroniser, tick-qualified stability counter, clean level, edge pulses
// Ports: clk, rst (async active-low), tick (sample enable), noisy (raw pin),
//        level (debounced), rise / fall (one-clk pulses aligned with the level change)
module debounce_channel import keypad_pkg::*; #(
  parameter int   STABLE_TICKS = KP_STABLE_TICKS_DEF,
  parameter int   CNT_W        = $clog2(STABLE_TICKS + 1),
  parameter logic RST_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic noisy,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta, sync, differ, done;
  logic [CNT_W-1:0] cnt;
  assign differ = sync != level;
  assign done = tick && differ && cnt == CNT_W'(STABLE_TICKS - 1);
  // Pulses are registered from the same condition that flips level, so they
  // appear in exactly the cycle the new level is first visible.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta  <= RST_LEVEL;
      sync  <= RST_LEVEL;
      level <= RST_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta <= noisy;
      sync <= meta;
      rise <= done && sync;
      fall <= done && !sync;
      if (tick) begin
        cnt <= (done || !differ) ? '0 : cnt + 1'b1;
        if (done) level <= sync;
      end
    end
endmodule

// File: rtl/keypad_debounce_array.sv
// keypad_debounce_array: CHANNELS independent debounced sense lines for the keypad scanner
// Ports: clk, rst (async active-low), tick (slow sample strobe), noisy_in (raw pins),
//        clean_level, rise_pulse, fall_pulse (per channel), any_rise (registered OR of rise_pulse)
// Macro KEYPAD_DEBOUNCE_TICK_GEN_EN: build an internal TICK_DIV prescaler and ignore the tick port.
module keypad_debounce_array import keypad_pkg::*; #(
  parameter int   CHANNELS     = KP_CHANNELS,
  parameter int   STABLE_TICKS = KP_STABLE_TICKS_DEF,
  parameter int   CNT_W        = $clog2(STABLE_TICKS + 1),
  parameter logic RST_LEVEL    = 1'b0,
  parameter int   TICK_DIV     = KP_TICK_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] clean_level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_rise
);
  logic tick_i;
`ifdef KEYPAD_DEBOUNCE_TICK_GEN_EN
  localparam int PW = $clog2(TICK_DIV + 1);
  logic [PW-1:0] pre;
  logic unused_tick;
  assign unused_tick = tick;
  assign tick_i = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) pre <= '0;
    else pre <= tick_i ? '0 : pre + 1'b1;
`else
  localparam int unused_div = TICK_DIV;
  assign tick_i = tick;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .CNT_W       (CNT_W),
      .RST_LEVEL   (RST_LEVEL)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_i),
      .noisy(noisy_in[i]),
      .level(clean_level[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) any_rise <= 1'b0;
    else any_rise <= |rise_pulse;
endmodule

// File: tb/tb_keypad_debounce_array.sv
// tb_keypad_debounce_array: directed self-checking bench for keypad_debounce_array
module tb_keypad_debounce_array;
  import keypad_pkg::*;
  logic clk = 1'b0;
  logic rst, tick, any_rise;
  kp_lines_t noisy_in, clean_level, rise_pulse, fall_pulse;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_debounce_array #(
`ifdef KEYPAD_DEBOUNCE_TICK_GEN_EN
    .TICK_DIV(8)
`else
    .TICK_DIV(KP_TICK_DIV_DEF)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .noisy_in   (noisy_in),
    .clean_level(clean_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_rise   (any_rise)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_once;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; tick = 1'b0; noisy_in = 4'hF;
    idle(3);
    n_cmp++; if (clean_level !== 4'h0) begin n_bad++; $display("FAIL reset_level: got %h want 0", clean_level); end
    n_cmp++; if ({rise_pulse, fall_pulse, any_rise} !== 9'd0) begin n_bad++; $display("FAIL reset_pulses: got %h/%h/%b want 0", rise_pulse, fall_pulse, any_rise); end
    rst = 1'b1;
    idle(1);
    n_cmp++; if (clean_level !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || any_rise !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got %h %h %h %b want 0", clean_level, rise_pulse, fall_pulse, any_rise); end
    noisy_in = 4'h0;
    idle(4);
  endtask

  task automatic test_press;
    noisy_in = 4'b0100;
    idle(2);
    for (int t = 1; t <= 3; t++) begin
      tick_once;
      n_cmp++; if (clean_level !== 4'h0 || rise_pulse !== 4'h0) begin n_bad++; $display("FAIL press_early t%0d: got %h/%h want 0/0", t, clean_level, rise_pulse); end
      idle(9);
    end
    tick_once;
    n_cmp++; if (clean_level !== 4'b0100) begin n_bad++; $display("FAIL press_level: got %h want 4", clean_level); end
    n_cmp++; if (rise_pulse !== 4'b0100 || fall_pulse !== 4'h0) begin n_bad++; $display("FAIL press_rise: got %h/%h want 4/0", rise_pulse, fall_pulse); end
    n_cmp++; if (any_rise !== 1'b0) begin n_bad++; $display("FAIL press_any_early: got %b want 0", any_rise); end
    idle(1);
    n_cmp++; if (rise_pulse !== 4'h0) begin n_bad++; $display("FAIL press_rise_width: got %h want 0", rise_pulse); end
    n_cmp++; if (any_rise !== 1'b1) begin n_bad++; $display("FAIL press_any: got %b want 1", any_rise); end
    idle(1);
    n_cmp++; if (any_rise !== 1'b0 || clean_level !== 4'b0100) begin n_bad++; $display("FAIL press_after: got %b/%h want 0/4", any_rise, clean_level); end
    idle(8);
  endtask

  task automatic test_bounce;
    noisy_in = 4'b0101; idle(2); tick_once; idle(9);
    noisy_in = 4'b0100; idle(2); tick_once; idle(9);
    noisy_in = 4'b0101; idle(2);
    for (int t = 3; t <= 5; t++) begin
      tick_once;
      n_cmp++; if (clean_level !== 4'b0100) begin n_bad++; $display("FAIL bounce_hold t%0d: got %h want 4", t, clean_level); end
      idle(9);
    end
    tick_once;
    n_cmp++; if (clean_level !== 4'b0101 || rise_pulse !== 4'b0001) begin n_bad++; $display("FAIL bounce_flip: got %h/%h want 5/1", clean_level, rise_pulse); end
    idle(9);
  endtask

  task automatic test_release;
    noisy_in = 4'b0111; idle(2);
    repeat (4) begin tick_once; idle(9); end
    n_cmp++; if (clean_level !== 4'b0111) begin n_bad++; $display("FAIL release_setup: got %h want 7", clean_level); end
    noisy_in = 4'b0101; idle(2);
    for (int t = 1; t <= 3; t++) begin
      tick_once;
      n_cmp++; if (clean_level !== 4'b0111 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
        n_bad++; $display("FAIL release_hold t%0d: got %h/%h/%h want 7/0/0", t, clean_level, rise_pulse, fall_pulse); end
      idle(9);
    end
    tick_once;
    n_cmp++; if (clean_level !== 4'b0101 || fall_pulse !== 4'b0010 || rise_pulse !== 4'h0) begin
      n_bad++; $display("FAIL release_fall: got %h/%h/%h want 5/2/0", clean_level, fall_pulse, rise_pulse); end
    idle(1);
    n_cmp++; if (fall_pulse !== 4'h0 || any_rise !== 1'b0) begin n_bad++; $display("FAIL release_width: got %h/%b want 0/0", fall_pulse, any_rise); end
    idle(8);
  endtask

  task automatic test_reset_mid;
    noisy_in = 4'b1101; idle(2);
    repeat (3) begin tick_once; idle(9); end
    n_cmp++; if (clean_level !== 4'b0101) begin n_bad++; $display("FAIL mid_before: got %h want 5", clean_level); end
    rst = 1'b0;
    #1;
    n_cmp++; if (clean_level !== 4'h0) begin n_bad++; $display("FAIL mid_async: got %h want 0", clean_level); end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    for (int t = 1; t <= 3; t++) begin
      tick_once;
      n_cmp++; if (clean_level !== 4'h0 || rise_pulse !== 4'h0) begin n_bad++; $display("FAIL mid_hold t%0d: got %h/%h want 0/0", t, clean_level, rise_pulse); end
      idle(9);
    end
    tick_once;
    n_cmp++; if (clean_level !== 4'b1101 || rise_pulse !== 4'b1101) begin n_bad++; $display("FAIL mid_flip: got %h/%h want d/d", clean_level, rise_pulse); end
    idle(1);
    n_cmp++; if (any_rise !== 1'b1 || rise_pulse !== 4'h0) begin n_bad++; $display("FAIL mid_any: got %b/%h want 1/0", any_rise, rise_pulse); end
  endtask

  task automatic test_tick_gen;
    int n;
    rst = 1'b0; tick = 1'b0; noisy_in = 4'h0;
    idle(2);
    rst = 1'b1;
    noisy_in = 4'b1000;
    n = 0;
    while (clean_level[3] !== 1'b1 && n < 100) begin
      tick = ~tick;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n < 27 || n > 34) begin n_bad++; $display("FAIL tickgen_latency: got %0d clk want 27..34", n); end
    n_cmp++; if (clean_level !== 4'b1000 || rise_pulse !== 4'b1000) begin n_bad++; $display("FAIL tickgen_level: got %h/%h want 8/8", clean_level, rise_pulse); end
  endtask

  initial begin
    test_reset;
`ifdef KEYPAD_DEBOUNCE_TICK_GEN_EN
    test_tick_gen;
`else
    test_press;
    test_bounce;
    test_release;
    test_reset_mid;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_debounce_array.md
Name: keypad_debounce_array

Overview:
- Parametrised multi-channel debouncer for the 4x4 keypad scanner's sense lines (rows/columns).
- Successor to the single-line two-flop edge debouncer. Adds:
  - 2-FF metastability synchroniser per channel.
  - Per-channel stability counter qualified by a slow tick.
  - Clean level output, plus separate rise and fall one-clock pulses.
- Sits between the FPGA pins and the keypad scan FSM.

Parameters:
- CHANNELS, 4, number of independent input lines.
- STABLE_TICKS, 4, consecutive ticks the synchronised input must differ from the clean level before the level flips; legal range 1..255.
- CNT_W, $clog2(STABLE_TICKS+1), stability counter width (derived; do not override).
- RST_LEVEL, 1'b0, reset value of every clean level and synchroniser flop.
- TICK_DIV, 100000, clk cycles per tick; used only when KEYPAD_DEBOUNCE_TICK_GEN_EN is defined.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- tick  input  1  slow sample enable, one clk cycle wide (the clk_lento strobe). Ignored when KEYPAD_DEBOUNCE_TICK_GEN_EN is defined.
- noisy_in  input  CHANNELS  raw asynchronous pin inputs.
- clean_level  output  CHANNELS  debounced level.
- rise_pulse  output  CHANNELS  one-clk pulse when clean_level goes 0->1.
- fall_pulse  output  CHANNELS  one-clk pulse when clean_level goes 1->0.
- any_rise  output  1  OR-reduction of rise_pulse, registered (one clk after rise_pulse).

Behaviour:
- Reset (rst low, asynchronous):
  - sync flops and clean_level = {CHANNELS{RST_LEVEL}}.
  - counters = 0.
  - rise_pulse, fall_pulse and any_rise = 0.
  - Deassertion takes effect at the next clk edge. Reset mid-count discards partial progress.
- Synchroniser: noisy_in passes through 2 flops every clk (not tick-gated). sync_in is the second flop.
- Per channel, evaluated only in clk cycles where the tick is high:
  - sync_in == clean_level: cnt <= 0 (bounce restarts the count).
  - sync_in != clean_level and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - sync_in != clean_level and cnt == STABLE_TICKS-1: clean_level <= sync_in; cnt <= 0.
- Tick low: cnt and clean_level hold.
- Tick held high continuously: behaves as tick every clk (legal; used in simulation).
- Edge pulses:
  - rise_pulse[i] / fall_pulse[i] are registered.
  - They are high for exactly the one clk cycle in which clean_level[i] first shows its new value; otherwise 0.
  - rise and fall on one channel are never high together.
- Latency: an input change held stable appears on clean_level 2 clk + between STABLE_TICKS-1 and STABLE_TICKS tick periods later (the first qualifying tick may land immediately or a full period later).
- STABLE_TICKS=1: level flips on the first tick where sync_in differs.
- Channels are fully independent. Simultaneous flips on several channels produce simultaneous pulses.
- Counter never exceeds STABLE_TICKS-1, so no wrap-around is possible.

Optional Feature:
- Macro: KEYPAD_DEBOUNCE_TICK_GEN_EN.
- Defined:
  - Internal prescaler counts 0..TICK_DIV-1 on clk and asserts an internal tick for one clk at terminal count.
  - Prescaler resets to 0 asynchronously.
  - The tick port is left unconnected internally.
- Undefined: no prescaler is built; the external tick port is used directly.

Decomposition:
- Shared package keypad_pkg:
  - KP_CHANNELS = 4 and KP_STABLE_TICKS_DEF = 4.
  - KP_TICK_DIV_DEF = 100000.
  - typedef kp_lines_t (logic [3:0]).
- Sub-module debounce_channel: one synchroniser, counter, level and edge-pulse slice. It is instantiated CHANNELS times in a generate loop. The top holds the optional prescaler and any_rise.

Test Plan:
1. Reset: rst=0 with noisy_in=4'hF -> clean_level=4'h0 and all pulses 0 while rst is low and in the first cycle after release.
2. Clean press, STABLE_TICKS=4, tick every 10 clk:
   - Stimulus: noisy_in[2] 0->1, held.
   - Response: clean_level[2] rises after 2 clk + 3 or 4 ticks. rise_pulse[2] high exactly 1 clk in that cycle. any_rise high 1 clk later. Other channels unaffected.
3. Bounce: noisy_in[0] toggles 1,0,1 across ticks 1-3, then held 1 -> count restarts on each mismatch. clean_level[0] rises only after 4 consecutive differing ticks.
4. Release: from clean_level[1]=1, noisy_in[1]->0 held -> fall_pulse[1] single clk; rise_pulse[1] stays 0.
5. Reset mid-count: after 3 differing ticks, pulse rst low for 1 clk -> cnt cleared. After release, 4 further differing ticks are needed before clean_level changes.
6. With KEYPAD_DEBOUNCE_TICK_GEN_EN and TICK_DIV=8:
   - Internal tick fires every 8 clk.
   - A stable press on noisy_in[3] sets clean_level[3] after 2 + 25..32 clk.
   - External tick toggling has no effect.
